// File: rtl/beta_alu_pkg.sv
// Shared definitions for the Beta ALU responder: function codes, FSM states, legality check.
// BETA_ALU_MUL_EN enables function code 2 (iterative multiply).
package beta_alu_pkg;

    localparam logic [3:0] FN_ADD   = 4'h0;
    localparam logic [3:0] FN_SUB   = 4'h1;
    localparam logic [3:0] FN_MUL   = 4'h2;
    localparam logic [3:0] FN_CMPEQ = 4'h4;
    localparam logic [3:0] FN_CMPLT = 4'h5;
    localparam logic [3:0] FN_CMPLE = 4'h6;
    localparam logic [3:0] FN_AND   = 4'h8;
    localparam logic [3:0] FN_OR    = 4'h9;
    localparam logic [3:0] FN_XOR   = 4'hA;
    localparam logic [3:0] FN_XNOR  = 4'hB;
    localparam logic [3:0] FN_SHL   = 4'hC;
    localparam logic [3:0] FN_SHR   = 4'hD;
    localparam logic [3:0] FN_SRA   = 4'hE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [3:0] fn);
        case (fn)
            4'h3, 4'h7, 4'hF: is_legal = 1'b0;
`ifdef BETA_ALU_MUL_EN
            FN_MUL:           is_legal = 1'b1;
`else
            FN_MUL:           is_legal = 1'b0;
`endif
            default:          is_legal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/beta_alu_mul.sv
// Iterative shift-add multiplier: one bit of b per cycle, WIDTH cycles from start to done.
// Only instantiated when BETA_ALU_MUL_EN is defined.
module beta_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // Bit 0 of b is retired in the load cycle so the product is ready WIDTH-1 cycles later,
    // letting the caller register it on the WIDTH-th edge after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt    <= cnt - CW'(1);
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/beta_alu_resp.sv
// Beta ALU responder: valid/ready request in, valid/ready result out, completed-response counter.
// BETA_ALU_MUL_EN compiles in the BUSY state and the iterative multiplier for code 2.
module beta_alu_resp
    import beta_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_fn,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ill,
    output logic [CNT_W-1:0] counter
);

    localparam int SH_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [3:0]       fn,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SH_W-1:0]         sh;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        alu_eval = '0;
        case (fn)
            FN_ADD:   alu_eval = a + b;
            FN_SUB:   alu_eval = a - b;
            FN_CMPEQ: alu_eval = WIDTH'(a == b);
            FN_CMPLT: alu_eval = WIDTH'(sa < sb);
            FN_CMPLE: alu_eval = WIDTH'(sa <= sb);
            FN_AND:   alu_eval = a & b;
            FN_OR:    alu_eval = a | b;
            FN_XOR:   alu_eval = a ^ b;
            FN_XNOR:  alu_eval = ~(a ^ b);
            FN_SHL:   alu_eval = a << sh;
            FN_SHR:   alu_eval = a >> sh;
            FN_SRA:   alu_eval = sa >>> sh;
            default:  alu_eval = '0;
        endcase
    endfunction

    state_t           state;
    logic             accept;
    logic             launch_mul;
    logic             launch_ill;
    logic [WIDTH-1:0] launch_data;

    // In DONE a new request can only enter when the pending result leaves in the same edge.
    always_comb begin
        req_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    req_ready = 1'b1;
                DONE:    req_ready = rsp_ready;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        launch_mul  = 1'b0;
`ifdef BETA_ALU_MUL_EN
        launch_mul  = (req_fn == FN_MUL);
`endif
        launch_ill  = !is_legal(req_fn);
        launch_data = launch_ill ? '0 : alu_eval(req_fn, req_a, req_b);
    end

`ifdef BETA_ALU_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    beta_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && launch_mul),
        .a       (req_a),
        .b       (req_b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rsp_data <= '0;
            rsp_ill  <= 1'b0;
            counter  <= '0;
        end else begin
            if (rsp_valid && rsp_ready)
                counter <= counter + CNT_W'(1);

            if (accept) begin
                if (launch_mul) begin
                    state <= BUSY;
                end else begin
                    state    <= DONE;
                    rsp_data <= launch_data;
                    rsp_ill  <= launch_ill;
                end
            end else begin
                case (state)
`ifdef BETA_ALU_MUL_EN
                    BUSY: begin
                        if (mul_done) begin
                            state    <= DONE;
                            rsp_data <= mul_product;
                            rsp_ill  <= 1'b0;
                        end
                    end
`endif
                    DONE: begin
                        if (rsp_ready)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/beta_alu_resp.md
# beta_alu_resp

Responder-side front-end for the Beta ALU. It accepts Beta ALU operation requests over a valid/ready handshake, evaluates them, and returns results over a second valid/ready handshake. It also keeps a running count of completed responses. It sits between the instruction-issue logic (or a bench initiator) and the register-file write-back path, and is the consumer end of the ALU request stream.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a power of two ≥ 8
- CNT_W, 16, width of the completed-operation counter

Ports (clock and reset first):
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready
- req_fn  in  4  Beta ALU function code (opcode bits [3:0])
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B (register or sign-extended literal; already resolved upstream)
- rsp_valid  out  1  result present
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  WIDTH  result
- rsp_ill  out  1  function code was illegal
- counter  out  CNT_W  number of completed response handshakes

## Operation
- Function codes: 0 ADD, 1 SUB, 2 MUL, 4 CMPEQ, 5 CMPLT (signed), 6 CMPLE (signed), 8 AND, 9 OR, A XOR, B XNOR, C SHL, D SHR, E SRA.
- Codes 3, 7 and F are illegal. An illegal code returns rsp_data=0 and rsp_ill=1. Every legal code returns rsp_ill=0.
- ADD, SUB and MUL return the low WIDTH bits; overflow is discarded.
- Compare operations return 1 or 0 zero-extended.
- Shifts use the low log2(WIDTH) bits of req_b. SRA replicates the sign bit.
- State machine:
  - IDLE: req_ready=1. On accept, a single-cycle function goes to DONE; MUL goes to BUSY.
  - BUSY: req_ready=0. Iterative multiply retires one bit of B per cycle. After WIDTH cycles it goes to DONE.
  - DONE: rsp_valid=1. On the rsp handshake it goes to IDLE. If req_valid is also high (req_ready=rsp_ready in DONE), the new request is accepted in the same cycle and the FSM moves directly to DONE or BUSY.
- rsp_data and rsp_ill stay stable while rsp_valid=1 and rsp_ready=0.
- counter increments by 1 on each rsp_valid && rsp_ready edge and wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values: req_ready=0 while reset is high; rsp_valid=0, rsp_data=0, rsp_ill=0, counter=0, FSM=IDLE.
- req_ready becomes 1 on the first cycle after reset deasserts.
- Single-cycle function accepted at edge N: rsp_valid=1 after edge N (visible in cycle N+1).
- MUL accepted at edge N: rsp_valid=1 after edge N+WIDTH.
- Throughput is one single-cycle op per clock when rsp_ready is held high.
- req_ready is combinational from the FSM state and rsp_ready only. It never depends on req_valid.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. No response is produced for the aborted request, and counter clears.
- The handshake in which a response and a new request complete in the same cycle counts once in counter (the response).

## Configuration
- BETA_ALU_MUL_EN defined: code 2 performs the iterative multiply described above.
- BETA_ALU_MUL_EN undefined: code 2 is illegal (rsp_data=0, rsp_ill=1, single-cycle latency). The BUSY state and the multiplier are not compiled in.

## Structure
- The beta_alu_pkg package holds:
  - function-code constants (FN_ADD … FN_SRA)
  - the FSM state enum (IDLE, BUSY, DONE)
  - an is_legal function, including the BETA_ALU_MUL_EN dependence
- Sub-module beta_alu_mul is an iterative shift-add multiplier with start/done, WIDTH cycles per operation, and a synchronous reset abort. It is instantiated only under BETA_ALU_MUL_EN.

## Test plan
- Reset, then ADD 0x00000005 + 0xFFFFFFFF with rsp_ready=1 → next cycle rsp_data=0x00000004, rsp_ill=0, counter=1.
- Back-to-back: CMPLT 0x80000000,1 then SRA 0x80000000,4 then SHL 1,31 on three consecutive cycles → rsp_data 1, 0xF8000000, 0x80000000 on three consecutive cycles; req_ready stays high; counter=3.
- Backpressure: XOR 0xFF00FF00,0x0FF00FF0 with rsp_ready=0 for 5 cycles → rsp_data=0xF0F0F0F0 held stable and req_ready=0 until rsp_ready rises, then counter increments exactly once.
- Illegal code 0xF with operands 7,9 → rsp_data=0, rsp_ill=1; counter still increments.
- MUL (BETA_ALU_MUL_EN defined) 0x00010001 × 0x00010001 → rsp_valid after exactly 32 cycles with rsp_data=0x00020001; without the macro → rsp_ill=1 after 1 cycle.
- Reset asserted at cycle 10 of a MUL → no response ever appears; outputs and counter are zero; req_ready=1 the cycle after reset drops; a following SUB 3−5 returns 0xFFFFFFFE.
